fetch_ctrl: RTL

- Sequencing controller for the fetch-stage PC register. Drives the PC register's pc_write/pc_nxt inputs and reads back its pc output.
- Issues one instruction-bus request at a time and buffers the returned instruction until decode accepts it.
- Applies trap and branch redirects, and squashes any in-flight fetch that a redirect makes stale.
- Sits between the PC register, the ibus, and decode.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_redirect_sel.sv | 22 ++
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller slice.
// Provides u64, the fetch FSM state enum and the default PC step.
package fetch_ctrl_pkg;

   typedef logic [63:0] u64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam u64 PC_STEP_DEFAULT = 64'd4;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect source priority mux: trap/return beats branch mispredict.
// Ports: trap_redirect/trap_target, br_redirect/br_target in; redir, target out.
module fetch_redirect_sel
   import fetch_ctrl_pkg::*;
(
   input  logic trap_redirect,
   input  u64   trap_target,
   input  logic br_redirect,
   input  u64   br_target,
   output logic redir,
   output u64   target
);

   always_comb begin
      redir  = trap_redirect | br_redirect;
      target = br_target;
      if (trap_redirect) begin
         target = trap_target;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: drives the PC register, issues one ibus
// request at a time, buffers the returned instruction until decode takes it,
// and applies trap/branch redirects, squashing stale in-flight fetches.
// Ports: clk, reset (sync, active-high); pc in, pc_write/pc_nxt out;
// ireq_valid/ireq_addr out, iresp_addr_ok/iresp_data_ok/iresp_data in;
// inst_valid/inst/inst_pc out, inst_ready in; trap_* and br_* redirects in.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt, perf_squash_cnt and
// perf_stall_cnt outputs.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter u64          PC_STEP = PC_STEP_DEFAULT,
   parameter int unsigned INST_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  u64                pc,
   output logic              pc_write,
   output u64                pc_nxt,
   output logic              ireq_valid,
   output u64                ireq_addr,
   input  logic              iresp_addr_ok,
   input  logic              iresp_data_ok,
   input  logic [INST_W-1:0] iresp_data,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output u64                inst_pc,
   input  logic              inst_ready,
   input  logic              trap_redirect,
   input  u64                trap_target,
   input  logic              br_redirect,
`ifdef FETCH_PERF_CNT_EN
   output u64                perf_fetch_cnt,
   output u64                perf_squash_cnt,
   output u64                perf_stall_cnt,
`endif
   input  u64                br_target
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic         squash;
   logic         squash_nxt;
   logic         capture;
   logic         issue;
   logic         redir;
   u64           target;

   fetch_redirect_sel u_redirect_sel (
      .trap_redirect (trap_redirect),
      .trap_target   (trap_target),
      .br_redirect   (br_redirect),
      .br_target     (br_target),
      .redir         (redir),
      .target        (target)
   );

   // PC update: a redirect overrides the sequential advance.
   always_comb begin
      pc_write = 1'b0;
      pc_nxt   = pc;
      if ((state != IDLE) && redir) begin
         pc_write = 1'b1;
         pc_nxt   = target;
      end else if ((state == HOLD) && inst_ready) begin
         pc_write = 1'b1;
         pc_nxt   = pc + PC_STEP;
      end
   end

   always_comb begin
      state_nxt  = state;
      squash_nxt = squash;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            // The request keeps its address; the response is dropped later.
            if (redir) begin
               squash_nxt = 1'b1;
            end
            if (iresp_addr_ok) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (iresp_data_ok) begin
               squash_nxt = 1'b0;
               if (squash || redir) begin
                  state_nxt = REQ;
               end else begin
                  capture   = 1'b1;
                  state_nxt = HOLD;
               end
            end else if (redir) begin
               squash_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (redir || inst_ready) begin
               state_nxt = REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Latch the post-update PC so the address is stable for the request.
   assign issue = (state_nxt == REQ) && (state != REQ);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         squash    <= 1'b0;
         ireq_addr <= '0;
         inst      <= '0;
         inst_pc   <= '0;
      end else begin
         state  <= state_nxt;
         squash <= squash_nxt;
         if (issue) begin
            ireq_addr <= pc_write ? pc_nxt : pc;
         end
         if (capture) begin
            inst    <= iresp_data;
            inst_pc <= ireq_addr;
         end
      end
   end

   assign ireq_valid = (state == REQ);

   // The buffered instruction is younger than any redirecting one.
   assign inst_valid = (state == HOLD) && !redir;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt  <= '0;
         perf_squash_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         if (inst_valid && inst_ready) begin
            perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         end
         if ((state == WAIT) && iresp_data_ok && (squash || redir)) begin
            perf_squash_cnt <= perf_squash_cnt + 64'd1;
         end
         if ((state == HOLD) && !inst_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 64'd1;
         end
      end
   end
`endif

endmodule
